fetch_unit: RTL and testbench

//  Instruction-fetch stage of the pipelined CPU. Owns the program counter and drives the

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the F-stage bundle type handed to the IF/ID register.
package cpu_pkg;

  localparam int unsigned AW         = 32;
  localparam int unsigned IW         = 48;
  localparam logic [AW-1:0] RESET_PC = '0;
  localparam int unsigned IMEM_WORDS = 5;
  localparam int unsigned CNT_W      = 16;

  // All-zero word is what IF/ID injects when it flushes a bubble.
  localparam logic [IW-1:0] NOP = '0;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          valid;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous ROM and re-aligns
// the returned word with the PC that produced it.
module fetch_unit #(
  parameter int unsigned   AW         = cpu_pkg::AW,
  parameter int unsigned   IW         = cpu_pkg::IW,
  parameter logic [AW-1:0] RESET_PC   = AW'(cpu_pkg::RESET_PC),
  parameter int unsigned   IMEM_WORDS = cpu_pkg::IMEM_WORDS,
  parameter int unsigned   CNT_W      = cpu_pkg::CNT_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             StallF,
  input  logic             BranchE,
  input  logic [AW-1:0]    BranchTargetE,
  output logic [AW-1:0]    ImemAddr,
  input  logic [IW-1:0]    ImemInstr,
  output logic [IW-1:0]    InstrF,
  output logic [AW-1:0]    PCF,
  output logic             ValidF,
  output logic             MisalignedE,
  output logic [CNT_W-1:0] FetchCount
);

  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    pend_pc_q, pend_pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;

  logic [AW-1:0]    tgt;
  logic [AW-1:0]    imem_addr;
  logic             valid_f;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return (addr >> 2) < AW'(IMEM_WORDS);
  endfunction

  assign tgt = {BranchTargetE[AW-1:2], 2'b00};

  // Priority is BranchE > StallF > sequential for both the ROM address and state update.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    mis_d        = 1'b0;
    imem_addr    = pc_q;

    if (BranchE) begin
      imem_addr    = tgt;
      pend_pc_d    = tgt;
      pend_valid_d = in_range(tgt);
      pc_d         = tgt + AW'(4);
      mis_d        = |BranchTargetE[1:0];
    end else if (StallF) begin
      // Re-reading the pending address keeps the ROM output, and so InstrF, steady.
      imem_addr    = pend_pc_q;
    end else begin
      pend_pc_d    = pc_q;
      pend_valid_d = in_range(pc_q);
      pc_d         = pc_q + AW'(4);
    end

    if (Reset) begin
      imem_addr = RESET_PC;
    end
  end

  // The word on the bus during a redirect belongs to the wrong path.
  assign valid_f = pend_valid_q && !BranchE && !Reset;
  assign cnt_d   = cnt_q + CNT_W'(valid_f && !StallF);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      mis_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      mis_q        <= mis_d;
    end
  end

  assign ImemAddr    = imem_addr;
  assign InstrF      = ImemInstr;
  assign PCF         = pend_pc_q;
  assign ValidF      = valid_f;
  assign MisalignedE = mis_q;
  assign FetchCount  = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: synchronous ROM model, stream-level reference
// model compared every cycle, directed scenarios plus randomized stall/branch/reset.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall, br;
  logic [AW-1:0]    tgt;
  logic [AW-1:0]    imem_addr;
  logic [IW-1:0]    imem_instr;
  logic [IW-1:0]    instr_f;
  logic [AW-1:0]    pc_f;
  logic             valid_f, mis_e;
  logic [CNT_W-1:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit dut (
    .CLK          (clk),
    .Reset        (rst),
    .StallF       (stall),
    .BranchE      (br),
    .BranchTargetE(tgt),
    .ImemAddr     (imem_addr),
    .ImemInstr    (imem_instr),
    .InstrF       (instr_f),
    .PCF          (pc_f),
    .ValidF       (valid_f),
    .MisalignedE  (mis_e),
    .FetchCount   (fetch_count)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [IMEM_WORDS];
  initial begin
    rom[0] = 48'hE023C000000F;
    rom[1] = 48'hE14004000005;
    rom[2] = 48'hE2C004000064;
    rom[3] = 48'hEA4084000000;
    rom[4] = 48'hEC3086000000;
  end

  function automatic bit word_exists(input logic [AW-1:0] a);
    return (a >> 2) < AW'(IMEM_WORDS);
  endfunction

  function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
    int unsigned idx;
    idx = a >> 2;
    return word_exists(a) ? rom[idx] : 'x;
  endfunction

  // Synchronous ROM: one-cycle read latency.
  always @(posedge clk) imem_instr <= word_at(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction being presented, the next sequential address,
  // the number delivered so far and whether the last redirect was misaligned.
  fetch_bundle_t m_cur;
  logic [AW-1:0] m_next   = RESET_PC;
  int unsigned   m_cnt    = 0;
  bit            m_mis    = 1'b0;
  logic [AW-1:0] m_aligned;

  initial m_cur = '{instr: '0, pc: RESET_PC, valid: 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur  = '{instr: '0, pc: RESET_PC, valid: 1'b0};
      m_next = RESET_PC;
      m_cnt  = 0;
      m_mis  = 1'b0;
    end else begin
      if (m_cur.valid && !br && !stall) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_mis = 1'b0;
      if (br) begin
        m_aligned = {tgt[AW-1:2], 2'b00};
        m_cur     = '{instr: word_at(m_aligned), pc: m_aligned, valid: word_exists(m_aligned)};
        m_next    = m_aligned + 4;
        m_mis     = tgt[1:0] != 2'b00;
      end else if (!stall) begin
        m_cur  = '{instr: word_at(m_next), pc: m_next, valid: word_exists(m_next)};
        m_next = m_next + 4;
      end
    end
  end

  // Compare process: every cycle, mid low phase, with the cycle's inputs settled.
  always @(negedge clk) begin
    logic [AW-1:0] exp_addr;
    logic          exp_valid;
    exp_addr  = rst ? RESET_PC : br ? {tgt[AW-1:2], 2'b00} : stall ? m_cur.pc : m_next;
    exp_valid = m_cur.valid && !br && !rst;
    check("cyc_addr",  64'(imem_addr),   64'(exp_addr));
    check("cyc_pcf",   64'(pc_f),        64'(m_cur.pc));
    check("cyc_valid", 64'(valid_f),     64'(exp_valid));
    check("cyc_mis",   64'(mis_e),       64'(m_mis));
    check("cyc_count", 64'(fetch_count), 64'(m_cnt));
    if (exp_valid) check("cyc_instr", 64'(instr_f), 64'(m_cur.instr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pcf",   64'(pc_f),        64'h0);
    check("rst_valid", 64'(valid_f),     64'h0);
    check("rst_count", 64'(fetch_count), 64'h0);
    check("rst_addr",  64'(imem_addr),   64'h0);
    check("rst_mis",   64'(mis_e),       64'h0);
    rst = 1'b0;

    // Start-up: first cycle invalid, then words 0 and 4 in order.
    @(negedge clk);
    check("t1_addr0",  64'(imem_addr), 64'h0);
    check("t1_valid0", 64'(valid_f),   64'h0);
    tick(); @(negedge clk);
    check("t1_pcf0",   64'(pc_f),      64'h0);
    check("t1_instr0", 64'(instr_f),   64'hE023C000000F);
    check("t1_valid1", 64'(valid_f),   64'h1);
    check("t1_addr4",  64'(imem_addr), 64'h4);
    tick(); @(negedge clk);
    check("t1_pcf4",   64'(pc_f),      64'h4);
    check("t1_instr4", 64'(instr_f),   64'hE14004000005);

    // Stall three cycles while PCF=8.
    tick(); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_pcf",   64'(pc_f),        64'h8);
      check("t2_addr",  64'(imem_addr),   64'h8);
      check("t2_instr", 64'(instr_f),     64'hE2C004000064);
      check("t2_count", 64'(fetch_count), 64'h2);
      if (i < 2) tick();
    end
    tick(); stall = 1'b0;
    @(negedge clk);
    check("t2_rel_pcf", 64'(pc_f), 64'h8);
    tick(); @(negedge clk);
    check("t2_next_pcf", 64'(pc_f),        64'hC);
    check("t2_count3",   64'(fetch_count), 64'h3);

    // Redirect to 0 while PCF=0x10.
    tick(); br = 1'b1; tgt = 32'h0;
    @(negedge clk);
    check("t3_pcf10", 64'(pc_f),      64'h10);
    check("t3_addr",  64'(imem_addr), 64'h0);
    check("t3_valid", 64'(valid_f),   64'h0);
    tick(); br = 1'b0;
    @(negedge clk);
    check("t3_pcf0",   64'(pc_f),        64'h0);
    check("t3_valid1", 64'(valid_f),     64'h1);
    check("t3_count",  64'(fetch_count), 64'h4);

    // Branch and stall together: branch wins.
    tick(); br = 1'b1; stall = 1'b1; tgt = 32'h8;
    @(negedge clk);
    check("t4_pcf4",  64'(pc_f),      64'h4);
    check("t4_addr",  64'(imem_addr), 64'h8);
    check("t4_valid", 64'(valid_f),   64'h0);

    // Misaligned target 0x6 fetches 0x4.
    tick(); stall = 1'b0; tgt = 32'h6;
    @(negedge clk);
    check("t4_pcf8",   64'(pc_f),        64'h8);
    check("t4_instr8", 64'(instr_f),     64'hE2C004000064);
    check("t5_addr",   64'(imem_addr),   64'h4);
    check("t4_count",  64'(fetch_count), 64'h5);
    tick(); br = 1'b0;
    @(negedge clk);
    check("t5_pcf4", 64'(pc_f),  64'h4);
    check("t5_mis1", 64'(mis_e), 64'h1);
    tick(); @(negedge clk);
    check("t5_mis0",  64'(mis_e),       64'h0);
    check("t5_count", 64'(fetch_count), 64'h6);

    // Run past the populated ROM.
    repeat (3) tick();
    @(negedge clk);
    check("t6_pcf14", 64'(pc_f),        64'h14);
    check("t6_valid", 64'(valid_f),     64'h0);
    check("t6_count", 64'(fetch_count), 64'h9);
    tick(); stall = 1'b1;
    @(negedge clk);
    check("t6_frozen", 64'(fetch_count), 64'h9);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(valid_f),     64'h0);
    check("t6_rst_count", 64'(fetch_count), 64'h0);
    check("t6_rst_pcf",   64'(pc_f),        64'h0);
    tick(); rst = 1'b0; stall = 1'b0;

    // PC wraps modulo 2^AW.
    br = 1'b1; tgt = 32'hFFFF_FFFC;
    @(negedge clk);
    check("wrap_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    tick(); br = 1'b0;
    @(negedge clk);
    check("wrap_pcf",   64'(pc_f),      64'hFFFF_FFFC);
    check("wrap_addr0", 64'(imem_addr), 64'h0);
    tick(); @(negedge clk);
    check("wrap_pcf0",  64'(pc_f),    64'h0);
    check("wrap_valid", 64'(valid_f), 64'h1);
    check("wrap_instr", 64'(instr_f), 64'hE023C000000F);

    // Randomized stall / branch / reset traffic.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst   = ($urandom_range(0, 149) == 0);
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0, 1:    tgt = 32'($urandom_range(0, 4)) * 4;
        2:       tgt = 32'($urandom_range(0, 4)) * 4 + 32'($urandom_range(1, 3));
        3:       tgt = 32'($urandom_range(5, 64)) * 4 + 32'($urandom_range(0, 3));
        default: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
    end
    tick();
    rst = 1'b0; stall = 1'b0; br = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
